dma_burst_engine: RTL and testbench

//  Parametrised AXI4 memory-to-memory DMA engine for the U-Net segmentation datapath (feature-map moves DDR<->on-chip).

---
 rtl/dma_burst_engine.sv | 187 ++++++++++++++++++
 tb/tb_dma_burst_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_engine.sv
// AXI4 memory-to-memory DMA: moves a transfer as bursts of at most MAX_BURST beats that never cross 4 KB.
// Optional feature macro: DMA_RESP_CHECK_EN (rresp/bresp/rlast checking with sticky error and early finish).
module dma_burst_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     xfer_beats,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W-1:0]    m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    output logic [ADDR_W-1:0]    m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [DATA_W-1:0]    m_axi_wdata,
    output logic [DATA_W/8-1:0]  m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [2:0]           dbg_state
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int PW    = $clog2(MAX_BURST) + 1;
    localparam int CW    = (LEN_W + 1 > 14) ? LEN_W + 1 : 14;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   buf_mem [MAX_BURST];

    logic [CW-1:0]       src_room, dst_room, blen_w;
    logic [PW-1:0]       blen, last_idx;
    logic [ADDR_W-1:0]   burst_bytes;

    // Burst length: smallest of remaining beats, buffer depth and room left in both 4 KB pages.
    always_comb begin
        src_room = (CW'(4096) - CW'(src_q[11:0])) >> BSH;
        dst_room = (CW'(4096) - CW'(dst_q[11:0])) >> BSH;
        blen_w   = CW'(rem_q);
        if (CW'(MAX_BURST) < blen_w) blen_w = CW'(MAX_BURST);
        if (src_room < blen_w)       blen_w = src_room;
        if (dst_room < blen_w)       blen_w = dst_room;
    end

    assign blen        = PW'(blen_w);
    assign last_idx    = blen - PW'(1);
    assign burst_bytes = ADDR_W'(blen) << BSH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_RD_DATA && m_axi_rvalid)
            buf_mem[wptr_q[PW-2:0]] <= m_axi_rdata;
    end

    // Readies are implied by state, so each handshake only needs the slave's valid/ready here.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                src_d   = src_addr & ~ADDR_W'(BYTES - 1);
                dst_d   = dst_addr & ~ADDR_W'(BYTES - 1);
                rem_d   = xfer_beats;
                err_d   = 1'b0;
                wptr_d  = '0;
                rptr_d  = '0;
                state_d = (xfer_beats == '0) ? S_FIN : S_RD_ADDR;
            end
            S_RD_ADDR: if (m_axi_arready) begin
                wptr_d  = '0;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: if (m_axi_rvalid) begin
                wptr_d = wptr_q + PW'(1);
`ifdef DMA_RESP_CHECK_EN
                if (m_axi_rresp != 2'b00 || m_axi_rlast != (wptr_q == last_idx))
                    err_d = 1'b1;
`endif
                if (wptr_q == last_idx) state_d = S_WR_ADDR;
            end
            S_WR_ADDR: if (m_axi_awready) begin
                rptr_d  = '0;
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (m_axi_wready) begin
                rptr_d = rptr_q + PW'(1);
                if (rptr_q == last_idx) state_d = S_WR_RESP;
            end
            S_WR_RESP: if (m_axi_bvalid) begin
                src_d = src_q + burst_bytes;
                dst_d = dst_q + burst_bytes;
                rem_d = rem_q - LEN_W'(blen);
`ifdef DMA_RESP_CHECK_EN
                if (m_axi_bresp != 2'b00) err_d = 1'b1;
`endif
                state_d = (rem_q == LEN_W'(blen) || err_d) ? S_FIN : S_RD_ADDR;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_arsize  = 3'(BSH);
        m_axi_awsize  = 3'(BSH);
        m_axi_arburst = 2'b01;
        m_axi_awburst = 2'b01;
        m_axi_arvalid = (state_q == S_RD_ADDR);
        m_axi_araddr  = m_axi_arvalid ? src_q : '0;
        m_axi_arlen   = m_axi_arvalid ? 8'(last_idx) : 8'd0;
        m_axi_rready  = (state_q == S_RD_DATA);
        m_axi_awvalid = (state_q == S_WR_ADDR);
        m_axi_awaddr  = m_axi_awvalid ? dst_q : '0;
        m_axi_awlen   = m_axi_awvalid ? 8'(last_idx) : 8'd0;
        m_axi_wvalid  = (state_q == S_WR_DATA);
        m_axi_wdata   = m_axi_wvalid ? buf_mem[rptr_q[PW-2:0]] : '0;
        m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
        m_axi_wlast   = m_axi_wvalid && (rptr_q == last_idx);
        m_axi_bready  = (state_q == S_WR_RESP);
        busy          = (state_q != S_IDLE) && (state_q != S_FIN);
        done          = (state_q == S_FIN);
        dbg_state     = state_q;
    end

`ifdef DMA_RESP_CHECK_EN
    assign error = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp, m_axi_rlast, m_axi_bresp, err_q};
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: AXI slave model with optional back-pressure,
// burst log tables and beat-by-beat data scoreboard against a fixed address pattern.
module tb_dma_burst_engine;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic [LW-1:0] xfer_beats = '0;
    logic          busy, done, error;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize, dbg_state;
    logic [1:0]    arburst, awburst;
    logic          arvalid, awvalid, rready, wvalid, wlast, bready;
    logic          arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [DW-1:0] rdata = '0, wdata;
    logic [3:0]    wstrb;
    logic [1:0]    rresp = 2'b00, bresp = 2'b00;
    logic          rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

    always #5 clk = ~clk;

    dma_burst_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .xfer_beats(xfer_beats),
        .busy(busy), .done(done), .error(error),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    bit            bp = 1'b0;
    bit            inject_berr = 1'b0;
    int            rd_left = 0, wr_left = 0, b_count = 0;
    bit            b_pending = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [AW-1:0] src_base = '0, dst_base = '0;
    logic [AW-1:0] ar_addr_log[$];
    logic [7:0]    ar_len_log[$];
    logic [AW-1:0] aw_addr_log[$];
    int            done_cnt = 0, wlast_cnt = 0, stall_err = 0, cross_err = 0, valid_seen = 0;
    bit            ar_stall = 0, aw_stall = 0, w_stall = 0;
    logic [AW-1:0] ar_hold_addr, aw_hold_addr;
    logic [7:0]    ar_hold_len;
    logic [DW-1:0] w_hold_data;
    logic          w_hold_last;

    function automatic bit rnd_ready();
        return bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Slave drives its side on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
        end else begin
            arready = rnd_ready();
            awready = rnd_ready();
            wready  = rnd_ready();
            rvalid  = (rd_left > 0) && rnd_ready();
            rdata   = pat(rd_addr);
            rlast   = (rd_left == 1);
            rresp   = 2'b00;
            bvalid  = b_pending && rnd_ready();
            bresp   = (inject_berr && b_count == 0) ? 2'b10 : 2'b00;
        end
    end

    // Slave observes handshakes on the rising edge (pre-edge DUT values).
    always @(posedge clk) begin
        if (rst) begin
            rd_left = 0; wr_left = 0; b_pending = 0;
            ar_stall = 0; aw_stall = 0; w_stall = 0;
        end else begin
            if (ar_stall && (!arvalid || araddr != ar_hold_addr || arlen != ar_hold_len)) stall_err++;
            if (aw_stall && (!awvalid || awaddr != aw_hold_addr)) stall_err++;
            if (w_stall && (!wvalid || wdata != w_hold_data || wlast != w_hold_last)) stall_err++;
            ar_stall = arvalid && !arready; ar_hold_addr = araddr; ar_hold_len = arlen;
            aw_stall = awvalid && !awready; aw_hold_addr = awaddr;
            w_stall  = wvalid && !wready;   w_hold_data = wdata;   w_hold_last = wlast;
            if (arvalid || awvalid) valid_seen++;
            if (done) done_cnt++;
            if (rvalid && rready) begin
                rd_addr += 4;
                rd_left--;
            end
            if (arvalid && arready) begin
                ar_addr_log.push_back(araddr);
                ar_len_log.push_back(arlen);
                if (int'(araddr[11:0]) + (int'(arlen) + 1) * 4 > 4096) cross_err++;
                rd_addr = araddr;
                rd_left = int'(arlen) + 1;
            end
            if (awvalid && awready) begin
                aw_addr_log.push_back(awaddr);
                if (int'(awaddr[11:0]) + (int'(awlen) + 1) * 4 > 4096) cross_err++;
                wr_addr = awaddr;
                wr_left = int'(awlen) + 1;
            end
            if (wvalid && wready) begin
                check("wdata", wdata, pat(src_base + (wr_addr - dst_base)));
                check("wlast", wlast, wr_left == 1);
                if (wlast) wlast_cnt++;
                if (wr_left == 1) b_pending = 1;
                wr_addr += 4;
                wr_left--;
            end
            if (bvalid && bready) begin
                b_pending = 0;
                b_count++;
            end
        end
    end

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete(); aw_addr_log.delete();
        done_cnt = 0; wlast_cnt = 0; b_count = 0; valid_seen = 0;
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input int beats);
        @(negedge clk);
        src_addr = s; dst_addr = d; xfer_beats = beats[LW-1:0]; start = 1'b1;
        src_base = s; dst_base = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check({tag, "_done_in_time"}, i < 3000, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wlast}, 6'b0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_const", {arsize, arburst, awsize, awburst}, {3'd2, 2'b01, 3'd2, 2'b01});
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // 40 beats, no stalls: 16,16,8
        clear_logs();
        launch(32'h1000, 32'h8000, 40);
        check("t1_busy", busy, 1);
        wait_done("t1");
        check("t1_nbursts", ar_addr_log.size(), 3);
        check("t1_arlen0", ar_len_log[0], 15);
        check("t1_arlen1", ar_len_log[1], 15);
        check("t1_arlen2", ar_len_log[2], 7);
        check("t1_araddr1", ar_addr_log[1], 32'h1040);
        check("t1_araddr2", ar_addr_log[2], 32'h1080);
        check("t1_awaddr2", aw_addr_log[2], 32'h8080);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_wlast_cnt", wlast_cnt, 3);
        check("t1_error", error, 0);
        check("t1_busy_end", busy, 0);

        // 4 KB split: 4 beats at 0xFF0 then 12 at 0x1000
        clear_logs();
        launch(32'h0FF0, 32'h2000, 16);
        wait_done("t2");
        check("t2_nbursts", ar_addr_log.size(), 2);
        check("t2_araddr0", ar_addr_log[0], 32'h0FF0);
        check("t2_arlen0", ar_len_log[0], 3);
        check("t2_araddr1", ar_addr_log[1], 32'h1000);
        check("t2_arlen1", ar_len_log[1], 11);
        check("t2_awaddr1", aw_addr_log[1], 32'h2010);
        check("t2_cross", cross_err, 0);

        // Back-pressure: 100 beats from 0x3F00 -> 16x6 + 4
        clear_logs();
        bp = 1'b1;
        launch(32'h3F00, 32'h5000, 100);
        wait_done("t3");
        bp = 1'b0;
        check("t3_nbursts", ar_addr_log.size(), 7);
        check("t3_arlen3", ar_len_log[3], 15);
        check("t3_araddr4", ar_addr_log[4], 32'h4000);
        check("t3_arlen6", ar_len_log[6], 3);
        check("t3_araddr6", ar_addr_log[6], 32'h4080);
        check("t3_wlast_vs_aw", wlast_cnt, aw_addr_log.size());
        check("t3_wlast_cnt", wlast_cnt, 7);
        check("t3_stable", stall_err, 0);
        check("t3_cross", cross_err, 0);
        check("t3_done_cnt", done_cnt, 1);

        // Zero-length transfer
        clear_logs();
        launch(32'h0100, 32'h0200, 0);
        check("t4_done_next", done, 1);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_done_one", done, 0);
        check("t4_no_valids", valid_seen, 0);
        check("t4_done_cnt", done_cnt, 1);

        // Start while busy is ignored
        clear_logs();
        launch(32'h0100, 32'h0200, 8);
        repeat (3) @(negedge clk);
        src_addr = 32'h9000; dst_addr = 32'hA000; xfer_beats = 24'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4b");
        check("t4b_nbursts", ar_addr_log.size(), 1);
        check("t4b_arlen0", ar_len_log[0], 7);
        check("t4b_araddr0", ar_addr_log[0], 32'h0100);
        check("t4b_done_cnt", done_cnt, 1);

        // Reset during WR_DATA
        clear_logs();
        launch(32'h0400, 32'h0600, 16);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                if (wvalid) break;
                @(negedge clk);
            end
            check("t5_reached_wdata", k < 200, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("t5_wvalid_rst", wvalid, 0);
        check("t5_busy_rst", busy, 0);
        check("t5_state_rst", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        clear_logs();
        launch(32'h6000, 32'h7000, 8);
        wait_done("t5b");
        check("t5b_nbursts", ar_addr_log.size(), 1);
        check("t5b_arlen0", ar_len_log[0], 7);
        check("t5b_done_cnt", done_cnt, 1);
        check("t5b_wlast_cnt", wlast_cnt, 1);

`ifdef DMA_RESP_CHECK_EN
        // SLVERR on the first of three bursts
        clear_logs();
        inject_berr = 1'b1;
        launch(32'h1000, 32'h8000, 40);
        wait_done("t6");
        inject_berr = 1'b0;
        check("t6_error", error, 1);
        check("t6_nbursts", ar_addr_log.size(), 1);
        check("t6_done_cnt", done_cnt, 1);
        repeat (3) @(negedge clk);
        check("t6_error_sticky", error, 1);
        clear_logs();
        launch(32'h0100, 32'h0200, 4);
        check("t6_error_cleared", error, 0);
        wait_done("t6b");
        check("t6b_error", error, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
